// File: rtl/lfsr_pattern_player.sv
// Round pattern generator: a Galois LFSR runs while en is high; on the fall of en the
// value is frozen and played out as timed one-hot LED symbols, ending with a done pulse.
module lfsr_pattern_player #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
  parameter logic [WIDTH-1:0] SEED        = 8'h01,
  parameter int               SEQ_LEN     = 4,
  parameter int               HOLD_CYCLES = 12500000,
  parameter int               GAP_CYCLES  = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lfsr_reset,
  input  logic             en,
  output logic [3:0]       led,
  output logic             playing,
  output logic             done,
  output logic [WIDTH-1:0] seq_value
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = $clog2(SEQ_LEN) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SEQ_LEN - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF  = (SEED == '0) ? WIDTH'(1) : SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_FINISH,
    S_WAIT
  } state_t;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_snap;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en_q;
  logic             w_fall;
  logic [WIDTH-1:0] w_shifted;
  logic [1:0]       w_sym;

  assign w_fall = r_en_q & ~en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_SHOW;
      S_SHOW: begin
        if (en)                      w_next = S_IDLE;
        else if (r_cnt == HOLD_LAST) w_next = S_GAP;
      end
      S_GAP: begin
        if (en)                     w_next = S_IDLE;
        else if (r_cnt == GAP_LAST) w_next = (r_idx == IDX_LAST) ? S_FINISH : S_SHOW;
      end
      S_FINISH: w_next = S_WAIT;
      S_WAIT:   if (en) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED_EFF;
      r_snap <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_en_q <= 1'b0;
    end else begin
      r_en_q <= en;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_snap <= r_lfsr;
            r_idx  <= '0;
            r_cnt  <= '0;
          end else if (en) begin
            r_lfsr <= lfsr_reset ? SEED_EFF : lfsr_step(r_lfsr);
          end
        end
        S_SHOW: begin
          if (!en) r_cnt <= (r_cnt == HOLD_LAST) ? '0 : r_cnt + 1'b1;
        end
        S_GAP: begin
          if (!en) begin
            if (r_cnt == GAP_LAST) begin
              r_cnt <= '0;
              if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Symbol idx occupies snapshot bits [2*idx+1 : 2*idx].
  assign w_shifted = r_snap >> {r_idx, 1'b0};
  assign w_sym     = w_shifted[1:0];

  always_comb begin
    led     = 4'b0000;
    playing = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_SHOW: begin
        led     = 4'b0001 << w_sym;
        playing = 1'b1;
      end
      S_GAP:    playing = 1'b1;
      S_FINISH: done    = 1'b1;
      default: ;
    endcase
  end

  assign seq_value = r_snap;

endmodule

// File: doc/lfsr_pattern_player.md
Name: lfsr_pattern_player

Overview:
- Responder to the game-control FSM. Consumes its `lfsr_reset` and `en` outputs.
- While `en`=1 it seeds or free-runs a Galois LFSR.
- On the falling edge of `en` (the play phase), it freezes the LFSR value as the round pattern. It then plays that pattern as a timed sequence of one-hot LED symbols and pulses `done` when finished.
- Sits between the control FSM and the board LEDs / answer checker.

Parameters:
- WIDTH, 8, LFSR width in bits.
- TAPS, 8'hB8, Galois feedback mask; the default is maximal length, period 255.
- SEED, 8'h01, value loaded while `lfsr_reset`=1; a value of 0 is replaced by 1.
- SEQ_LEN, 4, number of 2-bit symbols played; must satisfy 1 <= SEQ_LEN <= WIDTH/2.
- HOLD_CYCLES, 12500000, clocks each symbol LED is lit; must be >= 1.
- GAP_CYCLES, 2500000, dark clocks after each symbol; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- lfsr_reset  input  1  from the control FSM; 1 = hold LFSR at SEED.
- en  input  1  from the control FSM; 1 = idle/LFSR phase, 0 = play phase.
- led  output  4  one-hot current symbol; 0 when dark.
- playing  output  1  high in SHOW and GAP states.
- done  output  1  single-cycle pulse when the sequence completes.
- seq_value  output  WIDTH  captured pattern (snapshot), for the answer checker.

Behaviour:
- Reset (async): state=IDLE, lfsr=SEED (0 mapped to 1), snapshot=0, idx=0, cnt=0, en_q=0.
  - Outputs during and after reset: led=0, playing=0, done=0, seq_value=0.
  - en_q resets to 0, so `en` already low at reset release does not start play.
- en_q is a register of `en`. Fall event = en_q && !en.
- LFSR update, only in IDLE:
  - if en && lfsr_reset: lfsr <= SEED (0 mapped to 1).
  - else if en: lfsr <= lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1.
  - else: hold.
  - Frozen in all other states. Never reaches 0.
- Symbol i (0-based) = snapshot[2i+1:2i]. `led` = 4'b0001 << symbol. LED is combinational from registered state, idx and snapshot.
- States:
  - IDLE: on the fall event: snapshot <= lfsr (no step that cycle), idx <= 0, cnt <= 0, go to SHOW. The LED is valid from the cycle after that edge.
  - SHOW: led = onehot(symbol idx), playing=1. cnt increments; at cnt==HOLD_CYCLES-1: cnt <= 0, go to GAP.
  - GAP: led=0, playing=1. At cnt==GAP_CYCLES-1: cnt <= 0. If idx==SEQ_LEN-1, go to FINISH; else idx <= idx+1 and go to SHOW.
  - FINISH: done=1 for exactly one cycle, then go to WAIT.
  - WAIT: led=0, playing=0. When en==1, go to IDLE.
- Abort: en==1 sampled in SHOW or GAP returns to IDLE the next edge. led=0, playing=0 from then on, no done pulse, snapshot retained.
- If en is already 1 at FINISH, the path is FINISH, then WAIT, then IDLE on the next edge.
- seq_value always equals snapshot. It updates only on capture.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)). idx width: $clog2(SEQ_LEN)+1.
- Total play time from capture edge to done: SEQ_LEN*(HOLD_CYCLES+GAP_CYCLES) clocks. done is asserted in the following cycle.
- Mid-operation reset: immediate return to reset values, regardless of state.

Test Plan:
(All with SEED=8'h01, TAPS=8'hB8, SEQ_LEN=4, HOLD_CYCLES=3, GAP_CYCLES=2.)
1. Seed hold: en=1, lfsr_reset=1 for 10 cycles, then en=0 -> seq_value=8'h01. Symbols are 1,0,0,0, so led reads 0010, then 0001 three times.
2. LFSR stepping: en=1, lfsr_reset=0 for exactly 4 sampled edges, then en=0 -> seq_value=8'h17.
   - led: 1000 x3, 0 x2; 0010 x3, 0 x2; 0010 x3, 0 x2; 0001 x3, 0 x2.
   - playing=1 for 20 cycles, done=1 on cycle 21 only.
   - With 5 edges instead -> seq_value=8'hB3.
3. Abort: during the second SHOW of scenario 2, raise en=1 -> the next cycle has led=0 and playing=0. done never pulses. seq_value stays 8'h17.
4. Wait/restart: after done, hold en=0 for 10 cycles -> stays in WAIT with led=0 and no second done. Raising en returns to IDLE; LFSR resumes from 8'h17 when lfsr_reset=0.
5. Reset behaviour:
   - Assert reset mid-SHOW -> led, playing, done and seq_value are 0 immediately (async).
   - Release reset with en=0 -> no play starts.
6. Zero seed: SEED=0, en=1, lfsr_reset=1, then en=0 -> seq_value=8'h01, never 0.
